hblank_op_sequencer: RTL and testbench

- Controller that owns the shared iterative arithmetic unit (divider/multiplier) used by the donut renderer.
- During each horizontal blank it sequences the per-line setup operations: one start pulse per op, then it waits for done and captures the result.
- Once per frame it also runs the frame (rotation) op.
- Results are committed to double-buffered outputs exactly at the line boundary. A deadline monitor aborts any sequence that would overrun into active video.

---
 rtl/hblank_op_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_hblank_op_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hblank_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : hblank_op_sequencer
//  Purpose  : Owns the shared iterative arithmetic unit during horizontal
//             blank. Issues the per-line setup ops (line_a, line_b) on every
//             visible line that precedes another visible line, and the frame
//             op (frame_c) followed by the line ops on the last line of the
//             frame. Results collect in shadow registers and are committed to
//             the outputs on the final pixel of the line. A sequence still in
//             flight at that point is abandoned and the sticky overrun flag
//             is raised.
//  Ports    : clk48        pixel clock
//             rst          asynchronous reset, active-high
//             h_count      horizontal position from the timing generator
//             v_count      vertical position from the timing generator
//             op_start     one-cycle start pulse to the arithmetic unit
//             op_sel       op select (0=line_a, 1=line_b, 2=frame_c)
//             op_done      one-cycle completion pulse from the unit
//             op_result    unit result, valid with op_done
//             line_a       committed per-line result 0
//             line_b       committed per-line result 1
//             frame_c      committed per-frame result
//             setup_valid  last commit came from a completed sequence
//             busy         sequence in progress (ISSUE or WAIT)
//             overrun      sticky deadline-miss flag
//             clr_overrun  clears overrun (a new miss wins)
//  Revision : 1.0  initial release
// ============================================================================
module hblank_op_sequencer #(
  parameter int H_DISPLAY = 1220,
  parameter int H_TOTAL   = 1525,
  parameter int V_DISPLAY = 480,
  parameter int V_TOTAL   = 525,
  parameter int RES_W     = 16
) (
  input  logic             clk48,
  input  logic             rst,
  input  logic [10:0]      h_count,
  input  logic [9:0]       v_count,
  output logic             op_start,
  output logic [1:0]       op_sel,
  input  logic             op_done,
  input  logic [RES_W-1:0] op_result,
  output logic [RES_W-1:0] line_a,
  output logic [RES_W-1:0] line_b,
  output logic [RES_W-1:0] frame_c,
  output logic             setup_valid,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [1:0] c_op_a = 2'd0;
  localparam logic [1:0] c_op_b = 2'd1;
  localparam logic [1:0] c_op_c = 2'd2;

  localparam logic [10:0] c_h_trig     = 11'(H_DISPLAY);
  localparam logic [10:0] c_h_last     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  c_v_frame    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  c_v_line_end = 10'(V_DISPLAY - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_op_sel;
  logic             r_op_start;
  logic             r_busy;
  logic             r_frame_seq;
  logic             r_pending;
  logic [RES_W-1:0] r_sh_a;
  logic [RES_W-1:0] r_sh_b;
  logic [RES_W-1:0] r_sh_c;
  logic [RES_W-1:0] r_line_a;
  logic [RES_W-1:0] r_line_b;
  logic [RES_W-1:0] r_frame_c;
  logic             r_setup_valid;
  logic             r_overrun;

  logic       w_at_trig;
  logic       w_at_last;
  logic [1:0] w_state_nxt;
  logic [1:0] w_sel_nxt;
  logic       w_frame_nxt;
  logic       w_capture;
  logic       w_commit;
  logic       w_abort;
  logic       w_seq_end;

  assign w_at_trig = (h_count == c_h_trig);
  assign w_at_last = (h_count == c_h_last);

  // Both sequences end with line_b, so the op order needs no counter:
  // frame_c -> line_a -> line_b, and line_a -> line_b.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_op_sel;
    w_frame_nxt = r_frame_seq;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    w_seq_end   = 1'b0;

    case (r_state)
      c_st_idle: begin
        if (w_at_trig) begin
          if (v_count == c_v_frame) begin
            w_state_nxt = c_st_issue;
            w_sel_nxt   = c_op_c;
            w_frame_nxt = 1'b1;
          end else if (v_count < c_v_line_end) begin
            w_state_nxt = c_st_issue;
            w_sel_nxt   = c_op_a;
            w_frame_nxt = 1'b0;
          end
        end
      end
      c_st_issue: begin
        // Unit latency is at least one cycle; op_done here is stale.
        w_state_nxt = c_st_wait;
      end
      c_st_wait: begin
        if (op_done) begin
          w_capture = 1'b1;
          case (r_op_sel)
            c_op_c: begin
              w_sel_nxt   = c_op_a;
              w_state_nxt = c_st_issue;
            end
            c_op_a: begin
              w_sel_nxt   = c_op_b;
              w_state_nxt = c_st_issue;
            end
            default: begin
              w_state_nxt = c_st_done;
              w_seq_end   = 1'b1;
            end
          endcase
        end
      end
      default: begin
      end
    endcase

    // Line boundary: commit a finished sequence, or abandon one still in
    // flight. The deadline takes priority over a completion in the same
    // cycle, since the result could not be committed on this line anyway.
    if (w_at_last) begin
      if (r_state == c_st_done && r_pending) begin
        w_commit    = 1'b1;
        w_state_nxt = c_st_idle;
        w_sel_nxt   = c_op_a;
      end else if (r_state == c_st_issue || r_state == c_st_wait) begin
        w_abort     = 1'b1;
        w_capture   = 1'b0;
        w_seq_end   = 1'b0;
        w_state_nxt = c_st_idle;
        w_sel_nxt   = c_op_a;
      end
    end
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      r_state       <= c_st_idle;
      r_op_sel      <= c_op_a;
      r_op_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_seq   <= 1'b0;
      r_pending     <= 1'b0;
      r_sh_a        <= '0;
      r_sh_b        <= '0;
      r_sh_c        <= '0;
      r_line_a      <= '0;
      r_line_b      <= '0;
      r_frame_c     <= '0;
      r_setup_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op_sel    <= w_sel_nxt;
      r_frame_seq <= w_frame_nxt;
      // Decoded from the next state so both are true registers that line up
      // exactly with the ISSUE / ISSUE+WAIT cycles.
      r_op_start  <= (w_state_nxt == c_st_issue);
      r_busy      <= (w_state_nxt == c_st_issue) || (w_state_nxt == c_st_wait);

      if (w_capture) begin
        case (r_op_sel)
          c_op_a:  r_sh_a <= op_result;
          c_op_b:  r_sh_b <= op_result;
          default: r_sh_c <= op_result;
        endcase
      end

      if (w_seq_end) begin
        r_pending <= 1'b1;
      end else if (w_commit || w_abort) begin
        r_pending <= 1'b0;
      end

      if (w_commit) begin
        r_line_a      <= r_sh_a;
        r_line_b      <= r_sh_b;
        r_setup_valid <= 1'b1;
        if (r_frame_seq) begin
          r_frame_c <= r_sh_c;
        end
      end else if (w_abort) begin
        r_setup_valid <= 1'b0;
      end

      if (w_abort) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign op_start    = r_op_start;
  assign op_sel      = r_op_sel;
  assign busy        = r_busy;
  assign line_a      = r_line_a;
  assign line_b      = r_line_b;
  assign frame_c     = r_frame_c;
  assign setup_valid = r_setup_valid;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_hblank_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hblank_op_sequencer
//  Purpose  : Directed bench for hblank_op_sequencer. The bench plays the
//             timing generator (full 1525-pixel lines, chosen v_count) and a
//             fixed-latency arithmetic unit that answers each op_start after
//             u_lat cycles with the result preset for the selected op.
//             op_start for a trigger at h=1220 is seen during h=1221.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hblank_op_sequencer;

  logic        clk48 = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] h_count = '0;
  logic [9:0]  v_count = '0;
  logic        op_start;
  logic [1:0]  op_sel;
  logic        op_done = 1'b0;
  logic [15:0] op_result = '0;
  logic [15:0] line_a;
  logic [15:0] line_b;
  logic [15:0] frame_c;
  logic        setup_valid;
  logic        busy;
  logic        overrun;
  logic        clr_overrun = 1'b0;

  always #5 clk48 = ~clk48;

  hblank_op_sequencer dut (
    .clk48       (clk48),
    .rst         (rst),
    .h_count     (h_count),
    .v_count     (v_count),
    .op_start    (op_start),
    .op_sel      (op_sel),
    .op_done     (op_done),
    .op_result   (op_result),
    .line_a      (line_a),
    .line_b      (line_b),
    .frame_c     (frame_c),
    .setup_valid (setup_valid),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  // unit model
  int          u_lat = 20;
  int          u_cnt = 0;
  bit          u_pend = 1'b0;
  logic [1:0]  u_sel = '0;
  logic [15:0] u_res [3];

  // per-line observations
  int         st_h [$];
  logic [1:0] st_sel [$];
  bit         busy_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One full line. clr_h / rst_h select a pixel at which clr_overrun is held
  // for that cycle / rst is pulsed mid-cycle (-1 = never).
  task automatic run_line(input int v, input int lat, input int clr_h, input int rst_h);
    bit rel;
    rel = 1'b0;
    v_count = 10'(v);
    u_lat = lat;
    st_h.delete();
    st_sel.delete();
    busy_seen = 1'b0;
    for (int h = 0; h < 1525; h++) begin
      h_count = 11'(h);
      clr_overrun = (h == clr_h);
      if (h == rst_h) begin
        #3 rst = 1'b1;
        #1;
        chk("rst_op_start", 32'(op_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_line_a", 32'(line_a), 32'd0);
        chk("rst_line_b", 32'(line_b), 32'd0);
        chk("rst_frame_c", 32'(frame_c), 32'd0);
        chk("rst_valid", 32'(setup_valid), 32'd0);
        chk("rst_op_sel", 32'(op_sel), 32'd0);
        u_pend = 1'b0;
        rel = 1'b1;
      end
      @(posedge clk48);
      #1;
      if (rel) begin
        rst = 1'b0;
        rel = 1'b0;
      end
      if (busy) busy_seen = 1'b1;
      op_done = 1'b0;
      if (u_pend) begin
        u_cnt--;
        if (u_cnt == 0) begin
          op_done = 1'b1;
          op_result = u_res[u_sel];
          u_pend = 1'b0;
        end
      end
      if (op_start) begin
        st_h.push_back(h + 1);
        st_sel.push_back(op_sel);
        u_pend = 1'b1;
        u_cnt = u_lat;
        u_sel = op_sel;
      end
    end
    clr_overrun = 1'b0;
  endtask

  function automatic logic [31:0] sel_at(input int i);
    return (i < st_sel.size()) ? 32'(st_sel[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] h_at(input int i);
    return (i < st_h.size()) ? 32'(st_h[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    u_res[0] = 16'h0000;
    u_res[1] = 16'h0000;
    u_res[2] = 16'h0000;

    // reset state
    repeat (3) @(posedge clk48);
    #1;
    chk("reset_line_a", 32'(line_a), 32'd0);
    chk("reset_frame_c", 32'(frame_c), 32'd0);
    chk("reset_flags", {28'd0, op_start, busy, setup_valid, overrun}, 32'd0);
    chk("reset_op_sel", 32'(op_sel), 32'd0);
    rst = 1'b0;

    // line sequence, latency 20
    u_res[0] = 16'h1234; u_res[1] = 16'hABCD;
    run_line(10, 20, -1, -1);
    chk("l10_nstart", 32'(st_h.size()), 32'd2);
    chk("l10_start0_h", h_at(0), 32'd1221);
    chk("l10_start0_sel", sel_at(0), 32'd0);
    chk("l10_start1_h", h_at(1), 32'd1242);
    chk("l10_start1_sel", sel_at(1), 32'd1);
    chk("l10_line_a", 32'(line_a), 32'h1234);
    chk("l10_line_b", 32'(line_b), 32'hABCD);
    chk("l10_frame_c", 32'(frame_c), 32'h0);
    chk("l10_valid", 32'(setup_valid), 32'd1);
    chk("l10_overrun", 32'(overrun), 32'd0);

    // lines with no trigger
    run_line(479, 20, -1, -1);
    chk("l479_nstart", 32'(st_h.size()), 32'd0);
    chk("l479_busy", 32'(busy_seen), 32'd0);
    chk("l479_hold", {line_a, line_b}, 32'h1234ABCD);
    chk("l479_valid", 32'(setup_valid), 32'd1);
    run_line(480, 20, -1, -1);
    chk("l480_nstart", 32'(st_h.size()), 32'd0);
    run_line(523, 20, -1, -1);
    chk("l523_nstart", 32'(st_h.size()), 32'd0);
    chk("l523_busy", 32'(busy_seen), 32'd0);

    // frame sequence
    u_res[2] = 16'h0003; u_res[0] = 16'h0001; u_res[1] = 16'h0002;
    run_line(524, 20, -1, -1);
    chk("f_nstart", 32'(st_h.size()), 32'd3);
    chk("f_order", {sel_at(0)[7:0], sel_at(1)[7:0], sel_at(2)[7:0]}, 32'h00020001);
    chk("f_start2_h", h_at(2), 32'd1263);
    chk("f_frame_c", 32'(frame_c), 32'h0003);
    chk("f_line_a", 32'(line_a), 32'h0001);
    chk("f_line_b", 32'(line_b), 32'h0002);
    chk("f_valid", 32'(setup_valid), 32'd1);

    // deadline miss: op0 done at 1421, op1 issued 1422 due at 1622
    u_res[0] = 16'h5555; u_res[1] = 16'h6666;
    run_line(0, 200, -1, -1);
    chk("ov_nstart", 32'(st_h.size()), 32'd2);
    chk("ov_overrun", 32'(overrun), 32'd1);
    chk("ov_valid", 32'(setup_valid), 32'd0);
    chk("ov_hold", {line_a, line_b}, 32'h00010002);
    chk("ov_frame_c", 32'(frame_c), 32'h0003);
    chk("ov_op_sel", 32'(op_sel), 32'd0);

    // recovery; late done lands at h=97 while idle
    u_res[0] = 16'h7777; u_res[1] = 16'h8888;
    run_line(1, 20, -1, -1);
    chk("rec_nstart", 32'(st_h.size()), 32'd2);
    chk("rec_start0_h", h_at(0), 32'd1221);
    chk("rec_lines", {line_a, line_b}, 32'h77778888);
    chk("rec_valid", 32'(setup_valid), 32'd1);
    chk("rec_overrun", 32'(overrun), 32'd1);

    // clear in the same cycle as a new miss: set wins
    u_res[0] = 16'h9999; u_res[1] = 16'hAAAA;
    run_line(2, 200, 1524, -1);
    chk("setclr_overrun", 32'(overrun), 32'd1);
    chk("setclr_hold", {line_a, line_b}, 32'h77778888);
    chk("setclr_valid", 32'(setup_valid), 32'd0);
    u_res[0] = 16'h0A0A; u_res[1] = 16'h0B0B;
    run_line(3, 20, 10, -1);
    chk("clr_overrun", 32'(overrun), 32'd0);
    chk("clr_lines", {line_a, line_b}, 32'h0A0A0B0B);

    // reset in the middle of WAIT, then normal operation
    u_res[0] = 16'h1111; u_res[1] = 16'h2222;
    run_line(4, 200, -1, 1300);
    chk("postrst_nstart", 32'(st_h.size()), 32'd1);
    chk("postrst_lines", {line_a, line_b}, 32'h0);
    chk("postrst_busy", 32'(busy), 32'd0);
    run_line(5, 20, -1, -1);
    chk("resume_nstart", 32'(st_h.size()), 32'd2);
    chk("resume_lines", {line_a, line_b}, 32'h11112222);
    chk("resume_valid", 32'(setup_valid), 32'd1);
    chk("resume_frame_c", 32'(frame_c), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
